// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order front end: the instruction buffer entry,
// lane count and the opcode values agreed with decode.
package ooo_pkg;

    localparam int IB_LANES = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LD  = 4'h5;
    localparam logic [3:0] OP_ST  = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rt;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       a_dep;
        logic [3:0] a_own;
        logic       b_dep;
        logic [3:0] b_own;
    } ib_entry_t;

    function automatic logic [2:0] ib_min_lanes(input int n);
        return (n >= IB_LANES) ? 3'(IB_LANES) : 3'(n);
    endfunction

endpackage

// File: rtl/ib_lane_mux.sv
// One dispatch lane: picks entry (head + LANE) from storage and zeroes the
// lane when it lies beyond the current occupancy.
module ib_lane_mux
    import ooo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LANE  = 0
) (
    input  ib_entry_t                    entries_i [DEPTH],
    input  logic      [$clog2(DEPTH)-1:0] head_i,
    input  logic      [2:0]              out_count_i,
    output ib_entry_t                    entry_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    assign idx     = head_i + PTR_W'(LANE);
    assign entry_o = (3'(LANE) < out_count_i) ? entries_i[idx] : '0;

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction buffer between decode and dispatch: four lanes in,
// four oldest entries out, flushed by a taken jump.
module instr_buffer
    import ooo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LANES = IB_LANES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [2:0] in_count,
    input  logic [3:0] opcode_in          [0:LANES-1],
    input  logic [3:0] rt_in              [0:LANES-1],
    input  logic [3:0] ra_in              [0:LANES-1],
    input  logic [3:0] rb_in              [0:LANES-1],
    input  logic       op_a_local_dep_in  [0:LANES-1],
    input  logic       op_b_local_dep_in  [0:LANES-1],
    input  logic [3:0] op_a_owner_in      [0:LANES-1],
    input  logic [3:0] op_b_owner_in      [0:LANES-1],
    output logic [2:0] num_fetch,
    output logic [2:0] out_count,
    input  logic [2:0] deq_count,
    output logic [3:0] opcode_out         [0:LANES-1],
    output logic [3:0] rt_out             [0:LANES-1],
    output logic [3:0] ra_out             [0:LANES-1],
    output logic [3:0] rb_out             [0:LANES-1],
    output logic       op_a_local_dep_out [0:LANES-1],
    output logic       op_b_local_dep_out [0:LANES-1],
    output logic [3:0] op_a_owner_out     [0:LANES-1],
    output logic [3:0] op_b_owner_out     [0:LANES-1],
    output logic       overflow,
    output logic       underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ib_entry_t        mem_q    [DEPTH];
    ib_entry_t        entry_in [LANES];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             enq_ok, deq_ok;

    // Capacity seen by fetch ignores this cycle's dequeue on purpose.
    assign num_fetch = ib_min_lanes(DEPTH - int'(count_q));
    assign out_count = ib_min_lanes(int'(count_q));
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            entry_in[i] = '{opcode: opcode_in[i], rt: rt_in[i], ra: ra_in[i],
                            rb: rb_in[i], a_dep: op_a_local_dep_in[i],
                            a_own: op_a_owner_in[i], b_dep: op_b_local_dep_in[i],
                            b_own: op_b_owner_in[i]};
        end
    end

    always_comb begin
        enq_ok      = !flush && (in_count <= num_fetch);
        deq_ok      = !flush && (deq_count <= out_count);
        overflow_d  = overflow_q  | (!flush && (in_count > num_fetch));
        underflow_d = underflow_q | (!flush && (deq_count > out_count));
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_ok) tail_d = tail_q + PTR_W'(in_count);
            if (deq_ok) head_d = head_q + PTR_W'(deq_count);
            count_d = count_q + (enq_ok ? CNT_W'(in_count) : '0)
                              - (deq_ok ? CNT_W'(deq_count) : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (enq_ok && (3'(i) < in_count)) begin
                mem_q[tail_q + PTR_W'(i)] <= entry_in[i];
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        ib_entry_t lane_e;

        ib_lane_mux #(
            .DEPTH (DEPTH),
            .LANE  (j)
        ) u_lane_mux (
            .entries_i   (mem_q),
            .head_i      (head_q),
            .out_count_i (out_count),
            .entry_o     (lane_e)
        );

        assign opcode_out[j]         = lane_e.opcode;
        assign rt_out[j]             = lane_e.rt;
        assign ra_out[j]             = lane_e.ra;
        assign rb_out[j]             = lane_e.rb;
        assign op_a_local_dep_out[j] = lane_e.a_dep;
        assign op_a_owner_out[j]     = lane_e.a_own;
        assign op_b_local_dep_out[j] = lane_e.b_dep;
        assign op_b_owner_out[j]     = lane_e.b_own;
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Bench for instr_buffer: directed scenarios plus random traffic, all compared
// each cycle against a queue-based reference model.
module tb_instr_buffer;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] in_count, deq_count, num_fetch, out_count;
    logic [3:0] opcode_in [0:3], rt_in [0:3], ra_in [0:3], rb_in [0:3];
    logic       op_a_local_dep_in [0:3], op_b_local_dep_in [0:3];
    logic [3:0] op_a_owner_in [0:3], op_b_owner_in [0:3];
    logic [3:0] opcode_out [0:3], rt_out [0:3], ra_out [0:3], rb_out [0:3];
    logic       op_a_local_dep_out [0:3], op_b_local_dep_out [0:3];
    logic [3:0] op_a_owner_out [0:3], op_b_owner_out [0:3];
    logic       overflow, underflow;

    instr_buffer #(.DEPTH(DEPTH), .LANES(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .in_count           (in_count),
        .opcode_in          (opcode_in),
        .rt_in              (rt_in),
        .ra_in              (ra_in),
        .rb_in              (rb_in),
        .op_a_local_dep_in  (op_a_local_dep_in),
        .op_b_local_dep_in  (op_b_local_dep_in),
        .op_a_owner_in      (op_a_owner_in),
        .op_b_owner_in      (op_b_owner_in),
        .num_fetch          (num_fetch),
        .out_count          (out_count),
        .deq_count          (deq_count),
        .opcode_out         (opcode_out),
        .rt_out             (rt_out),
        .ra_out             (ra_out),
        .rb_out             (rb_out),
        .op_a_local_dep_out (op_a_local_dep_out),
        .op_b_local_dep_out (op_b_local_dep_out),
        .op_a_owner_out     (op_a_owner_out),
        .op_b_owner_out     (op_b_owner_out),
        .overflow           (overflow),
        .underflow          (underflow)
    );

    always #5 clk = ~clk;

    logic [25:0] mq [$];
    logic        m_ovf, m_unf;
    int          n_checks = 0;
    int          n_errors = 0;
    int          mode = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int min4(input int n);
        return (n > 4) ? 4 : n;
    endfunction

    function automatic logic [25:0] lane_in(input int i);
        return {opcode_in[i], rt_in[i], ra_in[i], rb_in[i], op_a_local_dep_in[i],
                op_a_owner_in[i], op_b_local_dep_in[i], op_b_owner_in[i]};
    endfunction

    function automatic logic [25:0] lane_out(input int j);
        return {opcode_out[j], rt_out[j], ra_out[j], rb_out[j], op_a_local_dep_out[j],
                op_a_owner_out[j], op_b_local_dep_out[j], op_b_owner_out[j]};
    endfunction

    task automatic compare_all();
        logic [25:0] exp;
        chk("num_fetch", 32'(num_fetch), 32'(min4(DEPTH - mq.size())));
        chk("out_count", 32'(out_count), 32'(min4(mq.size())));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        for (int j = 0; j < 4; j++) begin
            exp = (j < mq.size()) ? mq[j] : 26'd0;
            chk($sformatf("lane%0d", j), 32'(lane_out(j)), 32'(exp));
        end
    endtask

    // Reference behaviour at a rising edge, from the buffer's contract only.
    task automatic model_edge();
        int sz;
        sz = mq.size();
        if (flush) begin
            mq.delete();
        end else begin
            if (int'(deq_count) > min4(sz)) m_unf = 1'b1;
            else for (int k = 0; k < int'(deq_count); k++) void'(mq.pop_front());
            if (int'(in_count) > min4(DEPTH - sz)) m_ovf = 1'b1;
            else for (int k = 0; k < int'(in_count); k++) mq.push_back(lane_in(k));
        end
    endtask

    task automatic drive(input int in_n, input int deq_n, input logic fl);
        in_count  = 3'(in_n);
        deq_count = 3'(deq_n);
        flush     = fl;
        for (int i = 0; i < 4; i++) begin
            opcode_in[i]         = (mode == 1) ? 4'(i + 1) : 4'($urandom);
            rt_in[i]             = 4'($urandom);
            ra_in[i]             = 4'($urandom);
            rb_in[i]             = 4'($urandom);
            op_a_local_dep_in[i] = 1'($urandom);
            op_b_local_dep_in[i] = 1'($urandom);
            op_a_owner_in[i]     = (mode == 2) ? 4'(i + 5) : 4'($urandom);
            op_b_owner_in[i]     = 4'($urandom);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        in_count  = 3'd0;
        deq_count = 3'd0;
        flush     = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    task automatic random_phase(input int cycles, input bit allow_bad);
        int fr, oc, in_n, dq;
        logic fl;
        for (int c = 0; c < cycles; c++) begin
            fr   = min4(DEPTH - mq.size());
            oc   = min4(mq.size());
            in_n = allow_bad ? int'($urandom_range(0, 5)) : int'($urandom_range(0, fr));
            dq   = allow_bad ? int'($urandom_range(0, oc + 1)) : int'($urandom_range(0, oc));
            fl   = ($urandom_range(0, 19) == 0) && (in_n <= fr) && (dq <= oc);
            drive(in_n, dq, fl);
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_count  = 3'd0;
        deq_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            opcode_in[i] = '0; rt_in[i] = '0; ra_in[i] = '0; rb_in[i] = '0;
            op_a_local_dep_in[i] = 1'b0; op_b_local_dep_in[i] = 1'b0;
            op_a_owner_in[i] = '0; op_b_owner_in[i] = '0;
        end
        do_reset();

        // First group in program order, then fill and overflow.
        mode = 1;
        drive(4, 0, 1'b0);
        for (int k = 0; k < 4; k++) chk("opcode_order", 32'(opcode_out[k]), 32'(k + 1));
        mode = 0;
        repeat (3) drive(4, 0, 1'b0);
        chk("full_num_fetch", 32'(num_fetch), 32'd0);
        drive(2, 0, 1'b0);
        chk("full_overflow", 32'(overflow), 32'd1);

        do_reset();
        random_phase(400, 1'b0);

        // Walk head to 14 with an empty buffer, then straddle the wrap.
        do_reset();
        repeat (3) drive(4, 0, 1'b0);
        drive(2, 4, 1'b0);
        repeat (2) drive(0, 4, 1'b0);
        drive(0, 2, 1'b0);
        chk("wrap_empty", 32'(out_count), 32'd0);
        mode = 2;
        drive(4, 0, 1'b0);
        mode = 0;
        for (int k = 0; k < 4; k++) chk("wrap_a_own", 32'(op_a_owner_out[k]), 32'(k + 5));
        drive(0, 4, 1'b0);

        // Steady state and flush overriding traffic.
        do_reset();
        repeat (2) drive(4, 0, 1'b0);
        drive(3, 2, 1'b0);
        drive(1, 0, 1'b0);
        drive(4, 2, 1'b1);
        chk("flush_out_count", 32'(out_count), 32'd0);
        chk("flush_num_fetch", 32'(num_fetch), 32'd4);

        // Async reset with count 6 and both flags set.
        drive(4, 0, 1'b0);
        drive(2, 0, 1'b0);
        drive(5, 0, 1'b0);
        drive(0, 7, 1'b0);
        #2 rst = 1'b1;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        random_phase(300, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
